// File: rtl/avs_magnitude_memory.sv
// Avalon-MM sample memory with fixed wait-state stall and access counters.
// Define MAG_MEM_RANGE_CHECK_EN to flag and suppress out-of-range accesses.
module avs_magnitude_memory #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 256,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                     csi_clock_clk,
  input  logic                     csi_clock_reset,
  input  logic [ADDRESS_WIDTH-1:0] avs_avalonslave_address,
  input  logic                     avs_avalonslave_read,
  input  logic                     avs_avalonslave_write,
  input  logic [DATA_WIDTH-1:0]    avs_avalonslave_writedata,
  output logic [DATA_WIDTH-1:0]    avs_avalonslave_readdata,
  output logic                     avs_avalonslave_waitrequest,
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count,
  output logic                     err_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = ADDRESS_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [AW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wr;
  logic                  r_oor;
  logic                  r_waitrequest;
  logic [DATA_WIDTH-1:0] r_readdata;
  logic [15:0]           r_rd_count;
  logic [15:0]           r_wr_count;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [IW-1:0]         w_word;
  logic [AW-1:0]         w_idx;
  logic                  w_oor;
  logic                  w_req;
  logic                  w_to_resp;
  logic [AW-1:0]         w_rd_idx;
  logic                  w_rd_oor;
  logic                  w_rd_op;

  assign w_word = avs_avalonslave_address[ADDRESS_WIDTH-1:2];
  assign w_idx  = w_word[AW-1:0];
  assign w_req  = avs_avalonslave_read | avs_avalonslave_write;

`ifdef MAG_MEM_RANGE_CHECK_EN
  assign w_oor = (w_word >= IW'(DEPTH));
`else
  // Upper index bits are ignored so addresses wrap modulo DEPTH.
  logic w_unused_hi;
  assign w_unused_hi = ^w_word[IW-1:AW];
  assign w_oor       = 1'b0;
`endif

  // Read source for the RESP entry: live bus from IDLE, captured otherwise.
  always_comb begin
    w_to_resp = 1'b0;
    w_rd_idx  = r_idx;
    w_rd_oor  = r_oor;
    w_rd_op   = !r_wr;
    unique case (r_state)
      IDLE: begin
        w_to_resp = w_req && (WAIT_CYCLES == 0);
        w_rd_idx  = w_idx;
        w_rd_oor  = w_oor;
        w_rd_op   = !avs_avalonslave_write;
      end
      WAIT: w_to_resp = (r_cnt == 4'd1);
      default: ;
    endcase
  end

  always_ff @(posedge csi_clock_clk) begin
    if (csi_clock_reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_wdata       <= '0;
      r_wr          <= 1'b0;
      r_oor         <= 1'b0;
      r_waitrequest <= 1'b1;
      r_readdata    <= '0;
      r_rd_count    <= '0;
      r_wr_count    <= '0;
      r_err         <= 1'b0;
    end else begin
      r_waitrequest <= !w_to_resp;
      if (w_to_resp && w_rd_op)
        r_readdata <= w_rd_oor ? DATA_WIDTH'(32'hDEAD_BEEF)
                               : r_mem[w_rd_idx];
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx   <= w_idx;
            r_wdata <= avs_avalonslave_writedata;
            r_wr    <= avs_avalonslave_write;
            r_oor   <= w_oor;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= w_to_resp ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_to_resp)
            r_state <= RESP;
        end
        RESP: begin
          if (r_wr) begin
            if (r_wr_count != 16'hFFFF)
              r_wr_count <= r_wr_count + 16'd1;
          end else begin
            if (r_rd_count != 16'hFFFF)
              r_rd_count <= r_rd_count + 16'd1;
          end
          if (r_oor)
            r_err <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset in RESP suppresses the commit of a pending write.
  always_ff @(posedge csi_clock_clk) begin
    if (!csi_clock_reset && r_state == RESP && r_wr && !r_oor)
      r_mem[r_idx] <= r_wdata;
  end

  assign avs_avalonslave_readdata    = r_readdata;
  assign avs_avalonslave_waitrequest = r_waitrequest;
  assign rd_count                    = r_rd_count;
  assign wr_count                    = r_wr_count;
  assign err_flag                    = r_err;

endmodule

// File: tb/tb_avs_magnitude_memory.sv
// Bench for avs_magnitude_memory: one instance with two wait states,
// one with none, sharing a request bus gated by a select bit.
module tb_avs_magnitude_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, sel0;
  logic [31:0] addr, wdata;

  logic [31:0] q2, q0;
  logic        wq2, wq0;
  logic [15:0] rc2, wc2, rc0, wc0;
  logic        err2, err0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avs_magnitude_memory #(.WAIT_CYCLES(2)) d2 (
    .csi_clock_clk              (clk),
    .csi_clock_reset            (rst),
    .avs_avalonslave_address    (addr),
    .avs_avalonslave_read       (rd & ~sel0),
    .avs_avalonslave_write      (wr & ~sel0),
    .avs_avalonslave_writedata  (wdata),
    .avs_avalonslave_readdata   (q2),
    .avs_avalonslave_waitrequest(wq2),
    .rd_count                   (rc2),
    .wr_count                   (wc2),
    .err_flag                   (err2)
  );

  avs_magnitude_memory #(.WAIT_CYCLES(0)) d0 (
    .csi_clock_clk              (clk),
    .csi_clock_reset            (rst),
    .avs_avalonslave_address    (addr),
    .avs_avalonslave_read       (rd & sel0),
    .avs_avalonslave_write      (wr & sel0),
    .avs_avalonslave_writedata  (wdata),
    .avs_avalonslave_readdata   (q0),
    .avs_avalonslave_waitrequest(wq0),
    .rd_count                   (rc0),
    .wr_count                   (wc0),
    .err_flag                   (err0)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the target idle; returns at the next IDLE negedge.
  task automatic access(input logic s, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q, output int cyc);
    sel0 = s; rd = r; wr = w; addr = a; wdata = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((s ? wq0 : wq2) && cyc < 40);
    q = s ? q0 : q2;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        s, r, w;
    logic [31:0] a, d, q;
    int          cyc;
    logic [15:0] rc, wc;
  } vec_t;

  vec_t tv[10];

  initial begin
    logic [31:0] q;
    int          cyc;

    tv[0] = '{1'b0, 1'b0, 1'b1, 32'h10, 32'h0000_1234, 32'h0, 3, 16'd0, 16'd1};
    tv[1] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0000_1234, 3, 16'd1, 16'd1};
    tv[2] = '{1'b1, 1'b0, 1'b1, 32'h0, 32'h1111_1111, 32'h0, 1, 16'd0, 16'd1};
    tv[3] = '{1'b1, 1'b0, 1'b1, 32'h4, 32'h2222_2222, 32'h0, 1, 16'd0, 16'd2};
    tv[4] = '{1'b1, 1'b0, 1'b1, 32'h8, 32'h3333_3333, 32'h0, 1, 16'd0, 16'd3};
    tv[5] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 1, 16'd1, 16'd3};
    tv[6] = '{1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 32'h2222_2222, 1, 16'd2, 16'd3};
    tv[7] = '{1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 32'h3333_3333, 1, 16'd3, 16'd3};
    tv[8] = '{1'b0, 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 32'h0000_1234, 3, 16'd1, 16'd2};
    tv[9] = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A5_A5A5, 3, 16'd2, 16'd2};

    rst = 1'b1; rd = 1'b0; wr = 1'b0; sel0 = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_wreq2", {31'b0, wq2}, 32'h1);
    chk("rst_q2", q2, 32'h0);
    chk("rst_cnt2", {rc2, wc2}, 32'h0);
    chk("rst_err2", {31'b0, err2}, 32'h0);
    chk("rst_wreq0", {31'b0, wq0}, 32'h1);
    chk("rst_cnt0", {rc0, wc0}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_wreq2", {31'b0, wq2}, 32'h1);

    for (int i = 0; i < 10; i++) begin
      access(tv[i].s, tv[i].r, tv[i].w, tv[i].a, tv[i].d, q, cyc);
      chk($sformatf("v%0d_cyc", i), 32'(cyc), 32'(tv[i].cyc));
      chk($sformatf("v%0d_q", i), q, tv[i].q);
      chk($sformatf("v%0d_idle", i),
          {31'b0, tv[i].s ? wq0 : wq2}, 32'h1);
      chk($sformatf("v%0d_cnt", i),
          tv[i].s ? {rc0, wc0} : {rc2, wc2}, {tv[i].rc, tv[i].wc});
    end

    // Reset lands in the first WAIT cycle of a write.
    access(1'b0, 1'b0, 1'b1, 32'h30, 32'hCAFE_0030, q, cyc);
    sel0 = 1'b0; wr = 1'b1; addr = 32'h30; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rw_inwait", {31'b0, wq2}, 32'h1);
    rst = 1'b1; wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rw_cnt", {rc2, wc2}, 32'h0);
    chk("rw_q", q2, 32'h0);
    chk("rw_wreq", {31'b0, wq2}, 32'h1);
    access(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, q, cyc);
    chk("rw_old", q, 32'hCAFE_0030);
    chk("rw_cyc", 32'(cyc), 32'd3);
    chk("rw_cnt2", {rc2, wc2}, {16'd1, 16'd0});

    // Index 256 against DEPTH=256.
    access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_00AA, q, cyc);
    access(1'b0, 1'b0, 1'b1, 32'h400, 32'h5555_5555, q, cyc);
    access(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, q, cyc);
`ifdef MAG_MEM_RANGE_CHECK_EN
    chk("oor_rd", q, 32'hDEAD_BEEF);
    chk("oor_err", {31'b0, err2}, 32'h1);
`else
    chk("wrap_rd", q, 32'h5555_5555);
    chk("wrap_err", {31'b0, err2}, 32'h0);
`endif
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, q, cyc);
`ifdef MAG_MEM_RANGE_CHECK_EN
    chk("oor_keep0", q, 32'h0000_00AA);
    chk("oor_sticky", {31'b0, err2}, 32'h1);
`else
    chk("wrap_alias0", q, 32'h5555_5555);
    chk("wrap_err2", {31'b0, err2}, 32'h0);
`endif
    chk("oor_cnt", {rc2, wc2}, {16'd3, 16'd2});

    // Preload near saturation rather than issuing 65535 writes.
    d2.r_wr_count = 16'hFFFE;
    access(1'b0, 1'b0, 1'b1, 32'h40, 32'h1, q, cyc);
    chk("sat_ffff", {16'h0, wc2}, 32'h0000_FFFF);
    access(1'b0, 1'b0, 1'b1, 32'h44, 32'h2, q, cyc);
    chk("sat_hold", {16'h0, wc2}, 32'h0000_FFFF);
    chk("sat_rc", {16'h0, rc2}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
